// File: rtl/rc4_crack_dispatcher.sv
// Dynamic chunk dispatcher for a pool of RC4 cracker cores: round-robin chunk grants,
// first-match key latch with global abort, and exhaustion detection.
module rc4_crack_dispatcher #(
   parameter int NUM_CORES    = 4,
   parameter int SEARCH_W     = 22,
   parameter int KEY_W        = 24,
   parameter int CHUNK_LOG2   = 16,
   parameter int BEGIN_SEARCH = 0,
   parameter int END_SEARCH   = (1 << SEARCH_W) - 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start,
   input  logic [NUM_CORES-1:0]            core_req,
   output logic [NUM_CORES-1:0]            core_grant,
   output logic [SEARCH_W-1:0]             chunk_base,
   input  logic [NUM_CORES-1:0]            core_done,
   input  logic [NUM_CORES-1:0]            core_found,
   input  logic [NUM_CORES*SEARCH_W-1:0]   core_key,
   output logic                            core_abort,
   output logic                            busy,
   output logic                            key_valid,
   output logic [KEY_W-1:0]                key_out,
   output logic                            search_fail,
   output logic [SEARCH_W-CHUNK_LOG2:0]    chunks_done
);

   localparam int CW  = SEARCH_W - CHUNK_LOG2;
   localparam int PW  = CW + 1;
   localparam int RRW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [PW-1:0] FIRST_IDX = PW'(BEGIN_SEARCH >> CHUNK_LOG2);
   localparam logic [PW-1:0] LAST_IDX  = PW'(END_SEARCH >> CHUNK_LOG2);

   typedef enum logic [1:0] {IDLE, RUN, FOUND, FAIL} state_t;

   state_t               state;
   logic [NUM_CORES-1:0] owned;
   logic [PW-1:0]        chunk_ptr;
   logic [RRW-1:0]       rr_ptr;

   logic [NUM_CORES-1:0] eligible;
   logic [NUM_CORES-1:0] done_mask;
   logic [NUM_CORES-1:0] found_mask;
   logic [NUM_CORES-1:0] grant_vec;
   logic [NUM_CORES-1:0] owned_next;
   logic [SEARCH_W-1:0]  found_key;
   logic [PW-1:0]        done_count;
   logic [PW-1:0]        ptr_next;
   logic                 grant_valid;
   logic                 do_grant;
   int                   grant_idx;

   // Round-robin pick, done accounting and lowest-index found key for this cycle.
   always_comb begin
      eligible    = core_req & ~owned;
      done_mask   = core_done & owned;
      found_mask  = core_found & owned;
      grant_valid = 1'b0;
      grant_idx   = 0;
      done_count  = '0;
      found_key   = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_CORES;
         if (!grant_valid && eligible[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         done_count = done_count + PW'(done_mask[i]);
         if (found_mask[i])
            found_key = core_key[i*SEARCH_W +: SEARCH_W];
      end
      do_grant   = (state == RUN) && (chunk_ptr <= LAST_IDX) && grant_valid && (found_mask == '0);
      grant_vec  = do_grant ? (NUM_CORES'(1) << grant_idx) : '0;
      owned_next = (owned & ~done_mask) | grant_vec;
      ptr_next   = chunk_ptr + PW'(do_grant);
   end

   // Once a core reports a match, done/grant bookkeeping for that cycle is dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         owned       <= '0;
         chunk_ptr   <= FIRST_IDX;
         rr_ptr      <= '0;
         core_grant  <= '0;
         chunk_base  <= '0;
         core_abort  <= 1'b0;
         busy        <= 1'b0;
         key_valid   <= 1'b0;
         key_out     <= '0;
         search_fail <= 1'b0;
         chunks_done <= '0;
      end else begin
         core_grant <= '0;
         case (state)
            IDLE, FOUND, FAIL: begin
               if (start) begin
                  state       <= RUN;
                  owned       <= '0;
                  chunk_ptr   <= FIRST_IDX;
                  key_out     <= '0;
                  chunks_done <= '0;
                  busy        <= 1'b1;
                  key_valid   <= 1'b0;
                  search_fail <= 1'b0;
                  core_abort  <= 1'b0;
               end
            end
            RUN: begin
               if (found_mask != '0) begin
                  state      <= FOUND;
                  key_out    <= KEY_W'(found_key);
                  busy       <= 1'b0;
                  key_valid  <= 1'b1;
                  core_abort <= 1'b1;
               end else begin
                  owned       <= owned_next;
                  chunks_done <= chunks_done + done_count;
                  chunk_ptr   <= ptr_next;
                  if (do_grant) begin
                     core_grant <= grant_vec;
                     chunk_base <= {chunk_ptr[CW-1:0], {CHUNK_LOG2{1'b0}}};
                     rr_ptr     <= RRW'((grant_idx + 1) % NUM_CORES);
                  end
                  if ((ptr_next > LAST_IDX) && (owned_next == '0)) begin
                     state       <= FAIL;
                     busy        <= 1'b0;
                     search_fail <= 1'b1;
                     core_abort  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_crack_dispatcher.sv
// Directed self-checking bench for rc4_crack_dispatcher with 4 cores and an 8-chunk key space.
module tb_rc4_crack_dispatcher;

   localparam int NC = 4;
   localparam int SW = 6;
   localparam int KW = 24;
   localparam int CL = 3;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [NC-1:0]    core_req;
   logic [NC-1:0]    core_grant;
   logic [SW-1:0]    chunk_base;
   logic [NC-1:0]    core_done;
   logic [NC-1:0]    core_found;
   logic [NC*SW-1:0] core_key;
   logic             core_abort;
   logic             busy;
   logic             key_valid;
   logic [KW-1:0]    key_out;
   logic             search_fail;
   logic [SW-CL:0]   chunks_done;

   int tests_run = 0;
   int tests_failed = 0;

   rc4_crack_dispatcher #(
      .NUM_CORES(NC), .SEARCH_W(SW), .KEY_W(KW), .CHUNK_LOG2(CL),
      .BEGIN_SEARCH(0), .END_SEARCH(63)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .core_req(core_req),
      .core_grant(core_grant), .chunk_base(chunk_base), .core_done(core_done),
      .core_found(core_found), .core_key(core_key), .core_abort(core_abort),
      .busy(busy), .key_valid(key_valid), .key_out(key_out),
      .search_fail(search_fail), .chunks_done(chunks_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of core-side inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic [NC-1:0] req, input logic [NC-1:0] done, input logic [NC-1:0] found);
      core_req   = req;
      core_done  = done;
      core_found = found;
      @(posedge clk);
      #1;
   endtask

   task automatic resetAndStart();
      reset_n = 1'b0;
      start   = 1'b0;
      applyStimulus('0, '0, '0);
      reset_n = 1'b1;
      start   = 1'b1;
      applyStimulus('0, '0, '0);
      start   = 1'b0;
   endtask

   task automatic fillAllCores();
      for (int k = 0; k < NC; k++)
         applyStimulus(4'b1111, '0, '0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      core_req   = '0;
      core_done  = '0;
      core_found = '0;
      core_key   = '0;

      // Reset state
      applyStimulus('0, '0, '0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_grant", 32'(core_grant), 0);
      checkOutput("rst_abort", 32'(core_abort), 0);
      checkOutput("rst_keyvalid", 32'(key_valid), 0);
      checkOutput("rst_fail", 32'(search_fail), 0);
      checkOutput("rst_chunks", 32'(chunks_done), 0);

      // Round-robin grants on consecutive cycles, then a full search with no match
      resetAndStart();
      checkOutput("run_busy", 32'(busy), 1);
      for (int k = 0; k < NC; k++) begin
         applyStimulus(4'b1111, '0, '0);
         checkOutput("rr_grant", 32'(core_grant), 32'(1 << k));
         checkOutput("rr_base", 32'(chunk_base), 32'(8 * k));
      end
      applyStimulus(4'b1111, '0, '0);
      checkOutput("all_owned_grant", 32'(core_grant), 0);
      applyStimulus(4'b1111, 4'b1111, '0);
      checkOutput("done4_chunks", 32'(chunks_done), 4);
      checkOutput("done_cycle_grant", 32'(core_grant), 0);
      for (int k = 0; k < NC; k++) begin
         applyStimulus(4'b1111, '0, '0);
         checkOutput("rr2_grant", 32'(core_grant), 32'(1 << k));
         checkOutput("rr2_base", 32'(chunk_base), 32'(32 + 8 * k));
      end
      applyStimulus(4'b1111, '0, '0);
      checkOutput("exhausted_grant", 32'(core_grant), 0);
      checkOutput("pre_fail_busy", 32'(busy), 1);
      applyStimulus(4'b1111, 4'b1111, '0);
      checkOutput("fail_flag", 32'(search_fail), 1);
      checkOutput("fail_abort", 32'(core_abort), 1);
      checkOutput("fail_busy", 32'(busy), 0);
      checkOutput("fail_chunks", 32'(chunks_done), 8);
      applyStimulus(4'b1111, '0, '0);
      checkOutput("fail_no_grant", 32'(core_grant), 0);

      // Single find latches the key and freezes the dispatcher
      resetAndStart();
      fillAllCores();
      core_key = '0;
      core_key[2*SW +: SW] = 6'h2B;
      applyStimulus(4'b1111, '0, 4'b0100);
      checkOutput("find_valid", 32'(key_valid), 1);
      checkOutput("find_key", 32'(key_out), 32'h00002B);
      checkOutput("find_abort", 32'(core_abort), 1);
      checkOutput("find_busy", 32'(busy), 0);
      applyStimulus(4'b1111, 4'b1111, '0);
      checkOutput("found_ignore_grant", 32'(core_grant), 0);
      checkOutput("found_ignore_done", 32'(chunks_done), 0);
      checkOutput("found_hold_key", 32'(key_out), 32'h00002B);

      // Simultaneous finds: lowest index wins
      resetAndStart();
      fillAllCores();
      core_key = '0;
      core_key[1*SW +: SW] = 6'h11;
      core_key[3*SW +: SW] = 6'h39;
      applyStimulus(4'b1111, '0, 4'b1010);
      checkOutput("dual_find_key", 32'(key_out), 32'h000011);
      checkOutput("dual_find_valid", 32'(key_valid), 1);

      // Found/done on unowned cores are ignored
      resetAndStart();
      applyStimulus(4'b0010, '0, '0);
      checkOutput("single_grant", 32'(core_grant), 32'b0010);
      checkOutput("single_base", 32'(chunk_base), 0);
      core_key = '0;
      core_key[0 +: SW] = 6'h05;
      applyStimulus('0, 4'b0001, 4'b0001);
      checkOutput("unowned_found_busy", 32'(busy), 1);
      checkOutput("unowned_found_valid", 32'(key_valid), 0);
      checkOutput("unowned_done_chunks", 32'(chunks_done), 0);
      applyStimulus('0, 4'b0010, '0);
      checkOutput("owned_done_chunks", 32'(chunks_done), 1);

      // Mid-run reset clears everything; restart regrants from base 0
      resetAndStart();
      for (int k = 0; k < 3; k++)
         applyStimulus(4'b1111, '0, '0);
      checkOutput("pre_reset_base", 32'(chunk_base), 16);
      reset_n = 1'b0;
      applyStimulus(4'b1111, '0, '0);
      checkOutput("midrst_busy", 32'(busy), 0);
      checkOutput("midrst_grant", 32'(core_grant), 0);
      checkOutput("midrst_base", 32'(chunk_base), 0);
      reset_n = 1'b1;
      start   = 1'b1;
      applyStimulus('0, '0, '0);
      start   = 1'b0;
      applyStimulus(4'b1111, '0, '0);
      checkOutput("restart_grant", 32'(core_grant), 32'b0001);
      checkOutput("restart_base", 32'(chunk_base), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
